// File: rtl/rv32_pkg.sv
// Shared RV32 constants for the writeback stage: opcodes, writeback-select codes,
// load funct3 codes and the writeback FSM state type.
package rv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    WB_MEM  = 2'b00,
    WB_ALU  = 2'b01,
    WB_PC4  = 2'b10,
    WB_NONE = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_e;

  function automatic logic writes_rd(input logic [6:0] opcode);
    return opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
                          OPC_LOAD, OPC_OP_IMM, OPC_OP};
  endfunction

endpackage

// File: rtl/wb_unit_if.sv
// MEM/WB boundary bundle: incoming instruction, data-memory response and the
// register-file write port. master = upstream/memory side, slave = writeback unit.
interface wb_unit_if;
  logic        flush;
  logic        mem_valid;
  logic [31:0] mem_instr;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc_plus4;
  logic [1:0]  wb_sel;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_stall;
  logic        load_err;

  modport master (
    output flush, mem_valid, mem_instr, mem_alu_result, mem_pc_plus4, wb_sel,
           dmem_rvalid, dmem_rdata,
    input  rf_we, rf_waddr, rf_wdata, wb_stall, load_err
  );

  modport slave (
    input  flush, mem_valid, mem_instr, mem_alu_result, mem_pc_plus4, wb_sel,
           dmem_rvalid, dmem_rdata,
    output rf_we, rf_waddr, rf_wdata, wb_stall, load_err
  );
endinterface

// File: rtl/wb_unit_load_align.sv
// Load data alignment: picks the byte/half lane from the raw memory word,
// sign- or zero-extends it, and flags misaligned or illegal load widths.
module load_align
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane  = rdata[{addr, 3'b000} +: 8];
    half_lane  = addr[1] ? rdata[31:16] : rdata[15:0];
    data       = '0;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_lane[7]}}, byte_lane};
      F3_LBU: data = {24'b0, byte_lane};
      F3_LH: begin
        data       = {{16{half_lane[15]}}, half_lane};
        misaligned = addr[0];
      end
      F3_LHU: begin
        data       = {16'b0, half_lane};
        misaligned = addr[0];
      end
      F3_LW: begin
        data       = rdata;
        misaligned = (addr != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// RV32 writeback stage: MEM/WB register and sole register-file write port.
// Selects load/ALU/PC+4 results and holds the pipeline while a load response is late.
module wb_unit
  import rv32_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 64,
  parameter int XLEN         = 32
) (
  input logic      clk,
  input logic      rst,
  wb_unit_if.slave bus
);

  localparam int            CW       = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

  wb_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            discard_q, discard_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            load_err_q, load_err_d;
  logic            wb_stall;
  logic            commit;

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic            is_load, wr_ok, rvalid_eff, misaligned;
  logic [XLEN-1:0] load_data, result;
  logic            unused_instr_bits;

  assign opcode            = bus.mem_instr[6:0];
  assign rd                = bus.mem_instr[11:7];
  assign funct3            = bus.mem_instr[14:12];
  assign unused_instr_bits = ^bus.mem_instr[31:15];
  assign is_load           = (opcode == OPC_LOAD);
  assign wr_ok             = writes_rd(opcode) && (bus.wb_sel != WB_NONE) && (rd != 5'd0);
  // A response seen while discard is set belongs to an abandoned load.
  assign rvalid_eff        = bus.dmem_rvalid && !discard_q;

  load_align u_load_align (
    .funct3    (funct3),
    .addr      (bus.mem_alu_result[1:0]),
    .rdata     (bus.dmem_rdata),
    .data      (load_data),
    .misaligned(misaligned)
  );

  always_comb begin
    case (bus.wb_sel)
      WB_MEM:  result = load_data;
      WB_PC4:  result = bus.mem_pc_plus4;
      default: result = bus.mem_alu_result;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    discard_d  = discard_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    load_err_d = 1'b0;
    wb_stall   = 1'b0;
    commit     = 1'b0;

    if (bus.dmem_rvalid && discard_q) discard_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.mem_valid && !bus.flush) begin
          if (is_load && misaligned) begin
            load_err_d = 1'b1;
          end else if (is_load && !rvalid_eff) begin
            state_d  = ST_WAIT_LOAD;
            cnt_d    = '0;
            wb_stall = 1'b1;
          end else begin
            commit = 1'b1;
          end
        end
      end
      ST_WAIT_LOAD: begin
        if (bus.flush) begin
          state_d   = ST_IDLE;
          // A response arriving in the flush cycle is the killed load's own.
          discard_d = !rvalid_eff;
        end else if (rvalid_eff) begin
          state_d = ST_IDLE;
          commit  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_IDLE;
          load_err_d = 1'b1;
          discard_d  = 1'b1;
        end else begin
          wb_stall = 1'b1;
          cnt_d    = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit && wr_ok) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = rd;
      rf_wdata_d = result;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      discard_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      discard_q  <= discard_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.wb_stall = wb_stall;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: a transaction-level model predicts every
// output each cycle, plus literal expectations after key instructions.
module tb_wb_unit;

  localparam int LT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_unit_if bus ();

  wb_unit #(.LOAD_TIMEOUT(LT), .XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass     = 0;
  int n_total    = 0;
  int stall_seen = 0;
  bit chk_en     = 1'b0;

  logic        exp_we, exp_err, exp_stall;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  logic        nxt_we, nxt_err;
  logic [4:0]  nxt_waddr;
  logic [31:0] nxt_wdata;
  bit          discard_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit model_writes(input logic [31:0] instr, input logic [1:0] sel);
    return (instr[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                               7'b0000011, 7'b0010011, 7'b0110011})
           && (sel != 2'b11) && (instr[11:7] != 5'd0);
  endfunction

  function automatic bit model_misaligned(input logic [2:0] f3, input logic [1:0] addr);
    if (f3 == 3'd1 || f3 == 3'd5) return addr[0];
    if (f3 == 3'd2) return addr != 2'd0;
    return f3 inside {3'd3, 3'd6, 3'd7};
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] addr,
                                             input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * addr);
    case (f3)
      3'd0:    return 32'($signed(sh[7:0]));
      3'd1:    return 32'($signed(sh[15:0]));
      3'd4:    return {24'b0, sh[7:0]};
      3'd5:    return {16'b0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_result(input logic [31:0] instr, alu, pc4,
                                               input logic [1:0] sel, input logic [31:0] rdata);
    if (sel == 2'b10) return pc4;
    if (sel == 2'b00) return load_value(instr[14:12], alu[1:0], rdata);
    return alu;
  endfunction

  task automatic shift_exp();
    exp_we  = nxt_we;
    exp_err = nxt_err;
    if (nxt_we) begin
      exp_waddr = nxt_waddr;
      exp_wdata = nxt_wdata;
    end
    nxt_we  = 1'b0;
    nxt_err = 1'b0;
  endtask

  // resp/fl/rst_at: cycle index relative to issue (-1 = never); stale drives an old
  // response in the issue cycle.
  task automatic run(input logic [31:0] instr, alu, pc4, input logic [1:0] sel,
                     input int resp, input logic [31:0] rdata, input int fl,
                     input bit stale, input int rst_at);
    bit ld, mis, rv, rv_own, done;
    int c;
    ld   = (instr[6:0] == 7'b0000011);
    mis  = ld && model_misaligned(instr[14:12], alu[1:0]);
    done = 1'b0;
    c    = 0;
    while (!done) begin
      @(posedge clk);
      #1;
      shift_exp();
      rv                 = (c == resp) || (stale && c == 0);
      bus.mem_valid      = 1'b1;
      bus.mem_instr      = instr;
      bus.mem_alu_result = alu;
      bus.mem_pc_plus4   = pc4;
      bus.wb_sel         = sel;
      bus.flush          = (c == fl);
      bus.dmem_rvalid    = rv;
      bus.dmem_rdata     = (c == resp) ? rdata : 32'hDEADBEEF;
      rv_own = rv && !discard_m;
      if (rv && discard_m) discard_m = 1'b0;
      if (c == rst_at) begin
        rst = 1'b0;
        bus.mem_valid = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.flush = 1'b0;
        exp_we = 1'b0; exp_err = 1'b0; exp_waddr = '0; exp_wdata = '0; exp_stall = 1'b0;
        discard_m = 1'b0;
        done = 1'b1;
      end else if (c == fl) begin
        exp_stall = 1'b0;
        if (c > 0) discard_m = !rv_own;
        done = 1'b1;
      end else if (!ld || mis || rv_own) begin
        exp_stall = 1'b0;
        nxt_we    = !mis && model_writes(instr, sel);
        nxt_err   = mis;
        nxt_waddr = instr[11:7];
        nxt_wdata = model_result(instr, alu, pc4, sel, bus.dmem_rdata);
        done = 1'b1;
      end else if (c == LT) begin
        exp_stall = 1'b0;
        nxt_err   = 1'b1;
        discard_m = 1'b1;
        done = 1'b1;
      end else begin
        exp_stall = 1'b1;
      end
      c++;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    shift_exp();
    bus.mem_valid   = 1'b0;
    bus.flush       = 1'b0;
    bus.dmem_rvalid = 1'b0;
    exp_stall       = 1'b0;
  endtask

  task automatic settle(input string tag, input logic we, input logic [4:0] waddr,
                        input logic [31:0] wdata, input logic err);
    idle_cycle();
    @(negedge clk);
    check({tag, "_we"},    32'(bus.rf_we),    32'(we));
    check({tag, "_waddr"}, 32'(bus.rf_waddr), 32'(waddr));
    check({tag, "_wdata"}, bus.rf_wdata,      wdata);
    check({tag, "_err"},   32'(bus.load_err), 32'(err));
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (bus.wb_stall === 1'b1) stall_seen++;
    if (chk_en) begin
      check("cyc_rf_we",    32'(bus.rf_we),    32'(exp_we));
      check("cyc_rf_waddr", 32'(bus.rf_waddr), 32'(exp_waddr));
      check("cyc_rf_wdata", bus.rf_wdata,      exp_wdata);
      check("cyc_wb_stall", 32'(bus.wb_stall), 32'(exp_stall));
      check("cyc_load_err", 32'(bus.load_err), 32'(exp_err));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s0;
    rst = 1'b0;
    bus.flush = 1'b0; bus.mem_valid = 1'b0; bus.mem_instr = '0; bus.mem_alu_result = '0;
    bus.mem_pc_plus4 = '0; bus.wb_sel = 2'b11; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    exp_we = 0; exp_err = 0; exp_stall = 0; exp_waddr = '0; exp_wdata = '0;
    nxt_we = 0; nxt_err = 0; nxt_waddr = '0; nxt_wdata = '0; discard_m = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rf_we",    32'(bus.rf_we),    32'd0);
    check("reset_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    check("reset_rf_wdata", bus.rf_wdata,      32'd0);
    check("reset_wb_stall", 32'(bus.wb_stall), 32'd0);
    check("reset_load_err", 32'(bus.load_err), 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;

    // ADDI x5, latency 1
    run(32'h00A00293, 32'h0000000A, 32'h0, 2'b01, -1, 32'h0, -1, 0, -1);
    settle("addi", 1'b1, 5'd5, 32'h0000000A, 1'b0);

    // Load alignment with same-cycle response
    run(32'h00000303, 32'h00001003, 32'h0, 2'b00, 0, 32'h80FF1234, -1, 0, -1);
    settle("lb", 1'b1, 5'd6, 32'hFFFFFF80, 1'b0);
    run(32'h00004303, 32'h00001003, 32'h0, 2'b00, 0, 32'h80FF1234, -1, 0, -1);
    settle("lbu", 1'b1, 5'd6, 32'h00000080, 1'b0);
    run(32'h00001403, 32'h00001002, 32'h0, 2'b00, 0, 32'h80FF1234, -1, 0, -1);
    settle("lh", 1'b1, 5'd8, 32'hFFFF80FF, 1'b0);
    run(32'h00005483, 32'h00001000, 32'h0, 2'b00, 0, 32'h80FF1234, -1, 0, -1);
    settle("lhu", 1'b1, 5'd9, 32'h00001234, 1'b0);
    run(32'h00001403, 32'h00001001, 32'h0, 2'b00, -1, 32'h0, -1, 0, -1);
    settle("lh_mis", 1'b0, 5'd9, 32'h00001234, 1'b1);
    run(32'h00002383, 32'h00001002, 32'h0, 2'b00, -1, 32'h0, -1, 0, -1);
    settle("lw_mis", 1'b0, 5'd9, 32'h00001234, 1'b1);
    run(32'h00003303, 32'h00001000, 32'h0, 2'b00, -1, 32'h0, -1, 0, -1);
    settle("ld_illegal", 1'b0, 5'd9, 32'h00001234, 1'b1);

    // Late load: three stall cycles
    s0 = stall_seen;
    run(32'h00002383, 32'h00000100, 32'h0, 2'b00, 3, 32'hCAFEF00D, -1, 0, -1);
    settle("lw_late", 1'b1, 5'd7, 32'hCAFEF00D, 1'b0);
    #1 check("lw_late_stall_cycles", 32'(stall_seen - s0), 32'd3);

    // Timeout, then the stale response must be dropped
    s0 = stall_seen;
    run(32'h00002383, 32'h00000200, 32'h0, 2'b00, -1, 32'h0, -1, 0, -1);
    settle("lw_timeout", 1'b0, 5'd7, 32'hCAFEF00D, 1'b1);
    #1 check("lw_timeout_stall_cycles", 32'(stall_seen - s0), 32'd4);
    run(32'h00002583, 32'h00000300, 32'h0, 2'b00, 2, 32'h11112222, -1, 1, -1);
    settle("lw_after_stale", 1'b1, 5'd11, 32'h11112222, 1'b0);

    // Link writes and non-writing instructions
    run(32'h000000EF, 32'h0, 32'h00000104, 2'b10, -1, 32'h0, -1, 0, -1);
    settle("jal", 1'b1, 5'd1, 32'h00000104, 1'b0);
    run(32'h0000006F, 32'h0, 32'h00000208, 2'b10, -1, 32'h0, -1, 0, -1);
    settle("jal_x0", 1'b0, 5'd1, 32'h00000104, 1'b0);
    run(32'h00A12423, 32'h00000088, 32'h0, 2'b01, -1, 32'h0, -1, 0, -1);
    settle("store", 1'b0, 5'd1, 32'h00000104, 1'b0);
    run(32'h00208463, 32'h00000001, 32'h0, 2'b01, -1, 32'h0, -1, 0, -1);
    settle("branch", 1'b0, 5'd1, 32'h00000104, 1'b0);
    run(32'h12345537, 32'h12345000, 32'h0, 2'b11, -1, 32'h0, -1, 0, -1);
    settle("wbsel_none", 1'b0, 5'd1, 32'h00000104, 1'b0);

    // Flush of the incoming instruction leaves the prior write intact
    run(32'h00A00293, 32'h00000055, 32'h0, 2'b01, -1, 32'h0, -1, 0, -1);
    run(32'h12345537, 32'h12345000, 32'h0, 2'b01, -1, 32'h0, 0, 0, -1);
    settle("flush_incoming", 1'b0, 5'd5, 32'h00000055, 1'b0);

    // Flush in WAIT_LOAD with a response in the same cycle
    run(32'h00002383, 32'h00000400, 32'h0, 2'b00, 2, 32'h12345678, 2, 0, -1);
    settle("flush_wait", 1'b0, 5'd5, 32'h00000055, 1'b0);

    // Reset in the middle of a wait
    run(32'h00A00293, 32'h00000077, 32'h0, 2'b01, -1, 32'h0, -1, 0, -1);
    run(32'h00002383, 32'h00000500, 32'h0, 2'b00, -1, 32'h0, -1, 0, 2);
    @(negedge clk);
    check("midrst_rf_we",    32'(bus.rf_we),    32'd0);
    check("midrst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    check("midrst_rf_wdata", bus.rf_wdata,      32'd0);
    check("midrst_wb_stall", 32'(bus.wb_stall), 32'd0);
    check("midrst_load_err", 32'(bus.load_err), 32'd0);
    rst = 1'b1;
    run(32'h12345537, 32'h12345000, 32'h0, 2'b01, -1, 32'h0, -1, 0, -1);
    settle("lui_after_reset", 1'b1, 5'd10, 32'h12345000, 1'b0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
